// File: rtl/posi_edge_writer_pkg.sv
// Shared types and constants for the post-intra edge writer.
// Also provides fallback values for the PIXEL_WIDTH / PIC_X_WIDTH build macros.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 6
`endif

package posi_edge_writer_pkg;

  localparam logic [1:0] SIZE_4  = 2'd0;
  localparam logic [1:0] SIZE_8  = 2'd1;
  localparam logic [1:0] SIZE_16 = 2'd2;
  localparam logic [1:0] SIZE_32 = 2'd3;

  localparam int ROW_RAM_DEPTH = 240;
  localparam int COL_RAM_DEPTH = 256;
  localparam int FRA_RAM_DEPTH = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } posi_state_e;

  // Number of 4-pixel beats along one TU edge.
  function automatic logic [3:0] tu_beats(input logic [1:0] size);
    case (size)
      SIZE_4:  tu_beats = 4'd1;
      SIZE_8:  tu_beats = 4'd2;
      SIZE_16: tu_beats = 4'd4;
      default: tu_beats = 4'd8;
    endcase
  endfunction

  function automatic logic tu_aligned(input logic [1:0] size, input logic [3:0] x,
                                      input logic [3:0] y);
    logic [3:0] mask;
    mask = tu_beats(size) - 4'd1;
    tu_aligned = ((x & mask) == 4'd0) && ((y & mask) == 4'd0);
  endfunction

endpackage

// File: rtl/posi_edge_addr_gen.sv
// Combinational address mapping for one edge beat of a TU.
// Frame-address outputs exist only when POSI_FRA_WR_EN is defined.
module posi_edge_addr_gen
  import posi_edge_writer_pkg::*;
#(
  parameter int PIC_X_WIDTH = `PIC_X_WIDTH
) (
  input  logic [1:0]             size,
  input  logic [3:0]             cmd_x,
  input  logic [3:0]             cmd_y,
  input  logic [3:0]             k,
`ifdef POSI_FRA_WR_EN
  input  logic [PIC_X_WIDTH-1:0] lcu_x,
  output logic [PIC_X_WIDTH+3:0] fra_adr,
  output logic                   fra_sel,
`endif
  output logic [7:0]             row_adr,
  output logic [7:0]             col_adr,
  output logic                   row_sel
);

  logic [3:0] beats;
  logic [3:0] yl;
  logic [3:0] xl;
  logic [3:0] xk;
  logic [3:0] yk;

  assign beats = tu_beats(size);
  assign yl    = cmd_y + beats - 4'd1;
  assign xl    = cmd_x + beats - 4'd1;
  assign xk    = cmd_x + k;
  assign yk    = cmd_y + k;

  assign row_adr = {yl, xk};
  assign col_adr = {xl, yk};
  // Bottom LCU row (yl == 15) falls outside the 240-entry row RAM.
  assign row_sel = ({24'd0, row_adr} < ROW_RAM_DEPTH);

`ifdef POSI_FRA_WR_EN
  assign fra_adr = {lcu_x, xk};
  assign fra_sel = !row_sel;
`endif

endmodule

// File: rtl/posi_edge_writer.sv
// Write-side controller for the post-intra row/col/frame neighbour RAMs.
// Define POSI_FRA_WR_EN to enable frame RAM writes for LCU-bottom TUs.
//
// state     | meaning
// ST_IDLE   | waiting for a TU command, cmd_rdy_o high
// ST_STREAM | accepting edge beats until N have been taken
// ST_FLUSH  | last write issues, done_o pulses, back to idle
module posi_edge_writer
  import posi_edge_writer_pkg::*;
#(
  parameter int PIXEL_WIDTH = `PIXEL_WIDTH,
  parameter int PIC_X_WIDTH = `PIC_X_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [PIC_X_WIDTH-1:0]   lcu_x_i,
  input  logic                     cmd_val_i,
  output logic                     cmd_rdy_o,
  input  logic [1:0]               cmd_size_i,
  input  logic [3:0]               cmd_x_i,
  input  logic [3:0]               cmd_y_i,
  input  logic                     edge_val_i,
  output logic                     edge_rdy_o,
  input  logic [PIXEL_WIDTH*4-1:0] edge_row_dat_i,
  input  logic [PIXEL_WIDTH*4-1:0] edge_col_dat_i,
  input  logic                     stall_i,
  output logic                     row_wr_ena_o,
  output logic [7:0]               row_wr_adr_o,
  output logic [PIXEL_WIDTH*4-1:0] row_wr_dat_o,
  output logic                     col_wr_ena_o,
  output logic [7:0]               col_wr_adr_o,
  output logic [PIXEL_WIDTH*4-1:0] col_wr_dat_o,
  output logic                     fra_wr_ena_o,
  output logic [PIC_X_WIDTH+3:0]   fra_wr_adr_o,
  output logic [PIXEL_WIDTH*4-1:0] fra_wr_dat_o,
  output logic                     done_o
);

  posi_state_e state_q, state_d;

  logic [1:0] size_q;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic [3:0] cnt_q;
  logic       cmd_acc;
  logic       beat_acc;
  logic       last_beat;

  logic [7:0] row_adr;
  logic [7:0] col_adr;
  logic       row_sel;

  logic                     row_ena_q;
  logic [7:0]               row_adr_q;
  logic [PIXEL_WIDTH*4-1:0] row_dat_q;
  logic                     col_ena_q;
  logic [7:0]               col_adr_q;
  logic [PIXEL_WIDTH*4-1:0] col_dat_q;
  logic                     done_q;

  assign cmd_acc   = cmd_val_i && cmd_rdy_o;
  assign beat_acc  = edge_val_i && edge_rdy_o;
  assign last_beat = beat_acc && (cnt_q == tu_beats(size_q) - 4'd1);

  always_comb begin
    state_d    = state_q;
    cmd_rdy_o  = 1'b0;
    edge_rdy_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy_o = 1'b1;
        if (cmd_val_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        edge_rdy_o = !stall_i;
        if (last_beat) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= ST_IDLE;
      size_q  <= SIZE_4;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (cmd_acc) begin
        size_q <= cmd_size_i;
        x_q    <= cmd_x_i;
        y_q    <= cmd_y_i;
        cnt_q  <= 4'd0;
      end else if (beat_acc) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

`ifdef POSI_FRA_WR_EN
  logic [PIC_X_WIDTH-1:0]   lcu_x_q;
  logic [PIC_X_WIDTH+3:0]   fra_adr;
  logic                     fra_sel;
  logic                     fra_ena_q;
  logic [PIC_X_WIDTH+3:0]   fra_adr_q;
  logic [PIXEL_WIDTH*4-1:0] fra_dat_q;

  posi_edge_addr_gen #(.PIC_X_WIDTH(PIC_X_WIDTH)) u_addr_gen (
    .size    (size_q),
    .cmd_x   (x_q),
    .cmd_y   (y_q),
    .k       (cnt_q),
    .lcu_x   (lcu_x_q),
    .fra_adr (fra_adr),
    .fra_sel (fra_sel),
    .row_adr (row_adr),
    .col_adr (col_adr),
    .row_sel (row_sel)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      lcu_x_q   <= '0;
      fra_ena_q <= 1'b0;
      fra_adr_q <= '0;
      fra_dat_q <= '0;
    end else begin
      if (cmd_acc) lcu_x_q <= lcu_x_i;
      fra_ena_q <= beat_acc && fra_sel;
      if (beat_acc) begin
        fra_adr_q <= fra_adr;
        fra_dat_q <= edge_row_dat_i;
      end
    end
  end

  assign fra_wr_ena_o = fra_ena_q;
  assign fra_wr_adr_o = fra_adr_q;
  assign fra_wr_dat_o = fra_dat_q;
`else
  posi_edge_addr_gen #(.PIC_X_WIDTH(PIC_X_WIDTH)) u_addr_gen (
    .size    (size_q),
    .cmd_x   (x_q),
    .cmd_y   (y_q),
    .k       (cnt_q),
    .row_adr (row_adr),
    .col_adr (col_adr),
    .row_sel (row_sel)
  );

  assign fra_wr_ena_o = 1'b0;
  assign fra_wr_adr_o = '0;
  assign fra_wr_dat_o = '0;
`endif

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      row_ena_q <= 1'b0;
      row_adr_q <= 8'd0;
      row_dat_q <= '0;
      col_ena_q <= 1'b0;
      col_adr_q <= 8'd0;
      col_dat_q <= '0;
      done_q    <= 1'b0;
    end else begin
      row_ena_q <= beat_acc && row_sel;
      col_ena_q <= beat_acc;
      done_q    <= last_beat;
      if (beat_acc) begin
        row_adr_q <= row_adr;
        row_dat_q <= edge_row_dat_i;
        col_adr_q <= col_adr;
        col_dat_q <= edge_col_dat_i;
      end
    end
  end

  assign row_wr_ena_o = row_ena_q;
  assign row_wr_adr_o = row_adr_q;
  assign row_wr_dat_o = row_dat_q;
  assign col_wr_ena_o = col_ena_q;
  assign col_wr_adr_o = col_adr_q;
  assign col_wr_dat_o = col_dat_q;
  assign done_o       = done_q;

`ifndef SYNTHESIS
  // Misaligned commands are a caller error; the LCU index must be known at accept.
  a_cmd_aligned: assert property (@(posedge clk) disable iff (rstn)
    cmd_acc |-> (tu_aligned(cmd_size_i, cmd_x_i, cmd_y_i) && !$isunknown(lcu_x_i)));
`endif

endmodule

// File: tb/tb_posi_edge_writer.sv
// Randomized bench for posi_edge_writer against a transaction-level model.
module tb_posi_edge_writer;

  localparam int PW  = 8;
  localparam int PXW = 6;
`ifdef POSI_FRA_WR_EN
  localparam bit FRA_EN = 1'b1;
`else
  localparam bit FRA_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [PXW-1:0]  lcu_x_i = '0;
  logic            cmd_val_i = 1'b0;
  logic            cmd_rdy_o;
  logic [1:0]      cmd_size_i = '0;
  logic [3:0]      cmd_x_i = '0;
  logic [3:0]      cmd_y_i = '0;
  logic            edge_val_i = 1'b0;
  logic            edge_rdy_o;
  logic [PW*4-1:0] edge_row_dat_i = '0;
  logic [PW*4-1:0] edge_col_dat_i = '0;
  logic            stall_i = 1'b0;
  logic            row_wr_ena_o, col_wr_ena_o, fra_wr_ena_o, done_o;
  logic [7:0]      row_wr_adr_o, col_wr_adr_o;
  logic [PXW+3:0]  fra_wr_adr_o;
  logic [PW*4-1:0] row_wr_dat_o, col_wr_dat_o, fra_wr_dat_o;

  int checks = 0;
  int failures = 0;

  posi_edge_writer #(.PIXEL_WIDTH(PW), .PIC_X_WIDTH(PXW)) dut (
    .clk(clk), .rstn(rstn), .lcu_x_i(lcu_x_i),
    .cmd_val_i(cmd_val_i), .cmd_rdy_o(cmd_rdy_o), .cmd_size_i(cmd_size_i),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i),
    .edge_val_i(edge_val_i), .edge_rdy_o(edge_rdy_o),
    .edge_row_dat_i(edge_row_dat_i), .edge_col_dat_i(edge_col_dat_i), .stall_i(stall_i),
    .row_wr_ena_o(row_wr_ena_o), .row_wr_adr_o(row_wr_adr_o), .row_wr_dat_o(row_wr_dat_o),
    .col_wr_ena_o(col_wr_ena_o), .col_wr_adr_o(col_wr_adr_o), .col_wr_dat_o(col_wr_dat_o),
    .fra_wr_ena_o(fra_wr_ena_o), .fra_wr_adr_o(fra_wr_adr_o), .fra_wr_dat_o(fra_wr_dat_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction model: a TU is "busy" from accept until its flush cycle ends;
  // remaining counts beats still owed, and each accepted beat yields one write next cycle.
  bit        m_busy = 0;
  int        m_left = 0;
  int        m_size, m_x, m_y, m_lcu, m_k;
  bit        w_v = 0, w_row = 0, w_fra = 0, w_last = 0;
  int        w_row_adr, w_col_adr, w_fra_adr;
  logic [31:0] w_rdat, w_cdat;

  always @(negedge clk) begin
    bit   n_v, n_row, n_fra, n_last;
    int   n_row_adr, n_col_adr, n_fra_adr, n, yl, xl, xk, yk;
    logic [31:0] n_rdat, n_cdat;
    if (rstn) begin
      chk("rst_cmd_rdy", cmd_rdy_o, 1);
      chk("rst_edge_rdy", edge_rdy_o, 0);
      chk("rst_enables", {row_wr_ena_o, col_wr_ena_o, fra_wr_ena_o, done_o}, 0);
      chk("rst_adr", {row_wr_adr_o, col_wr_adr_o, fra_wr_adr_o}, 0);
      chk("rst_dat", {row_wr_dat_o, col_wr_dat_o}, 0);
      chk("rst_fra_dat", fra_wr_dat_o, 0);
      m_busy = 0; m_left = 0; w_v = 0;
    end else begin
      chk("cmd_rdy", cmd_rdy_o, !m_busy);
      chk("edge_rdy", edge_rdy_o, m_busy && m_left > 0 && !stall_i);
      chk("row_ena", row_wr_ena_o, w_v && w_row);
      chk("col_ena", col_wr_ena_o, w_v);
      chk("fra_ena", fra_wr_ena_o, w_v && w_fra);
      chk("done", done_o, w_v && w_last);
      if (w_v && w_row) begin
        chk("row_adr", row_wr_adr_o, w_row_adr);
        chk("row_dat", row_wr_dat_o, w_rdat);
      end
      if (w_v) begin
        chk("col_adr", col_wr_adr_o, w_col_adr);
        chk("col_dat", col_wr_dat_o, w_cdat);
      end
      if (w_v && w_fra) begin
        chk("fra_adr", fra_wr_adr_o, w_fra_adr);
        chk("fra_dat", fra_wr_dat_o, w_rdat);
      end
      n_v = 0; n_row = 0; n_fra = 0; n_last = 0;
      n_row_adr = 0; n_col_adr = 0; n_fra_adr = 0; n_rdat = '0; n_cdat = '0;
      if (!m_busy) begin
        if (cmd_val_i) begin
          m_busy = 1; m_size = cmd_size_i; m_x = cmd_x_i; m_y = cmd_y_i;
          m_lcu = lcu_x_i; m_k = 0; m_left = 1 << m_size;
        end
      end else if (m_left > 0) begin
        if (edge_val_i && !stall_i) begin
          n  = 1 << m_size;
          yl = (m_y + n - 1) % 16;
          xl = (m_x + n - 1) % 16;
          xk = (m_x + m_k) % 16;
          yk = (m_y + m_k) % 16;
          n_v = 1;
          n_row = (yl != 15);
          n_fra = FRA_EN && (yl == 15);
          n_row_adr = yl * 16 + xk;
          n_col_adr = xl * 16 + yk;
          n_fra_adr = m_lcu * 16 + xk;
          n_rdat = edge_row_dat_i;
          n_cdat = edge_col_dat_i;
          m_k++; m_left--;
          n_last = (m_left == 0);
        end
      end else begin
        m_busy = 0;
      end
      w_v = n_v; w_row = n_row; w_fra = n_fra; w_last = n_last;
      w_row_adr = n_row_adr; w_col_adr = n_col_adr; w_fra_adr = n_fra_adr;
      w_rdat = n_rdat; w_cdat = n_cdat;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y,
                          input logic [PXW-1:0] lx);
    bit got = 0;
    cmd_val_i = 1; cmd_size_i = s; cmd_x_i = x; cmd_y_i = y; lcu_x_i = lx;
    edge_val_i = 1'($urandom % 2);
    stall_i = 0;
    for (int g = 0; g < 20 && !got; g++) begin
      @(negedge clk);
      got = cmd_rdy_o;
      step();
    end
    cmd_val_i = 0;
    edge_val_i = 0;
    if (!got) begin
      failures++;
      $display("FAIL cmd_accept_timeout actual=0 required=1");
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 a 3-cycle window early in the TU.
  task automatic run_tu(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y,
                        input logic [PXW-1:0] lx, input int stall_mode, input int abort_at);
    int beats = 0;
    int guard = 0;
    int n = 1 << s;
    send_cmd(s, x, y, lx);
    while (beats < n && guard < 200) begin
      if (abort_at > 0 && beats == abort_at) begin
        rstn = 1;
        edge_val_i = 0; stall_i = 0;
        step();
        rstn = 0;
        return;
      end
      edge_val_i     = (stall_mode == 2) ? 1'b1 : 1'($urandom % 4 != 0);
      stall_i        = (stall_mode == 1) ? 1'($urandom % 4 == 0) :
                       (stall_mode == 2) ? (guard >= 1 && guard <= 3) : 1'b0;
      edge_row_dat_i = $urandom;
      edge_col_dat_i = $urandom;
      cmd_val_i      = 1'($urandom % 2);
      cmd_size_i     = 2'($urandom);
      cmd_x_i        = 4'($urandom);
      cmd_y_i        = 4'($urandom);
      @(negedge clk);
      if (edge_val_i && edge_rdy_o) beats++;
      step();
      guard++;
    end
    cmd_val_i = 0;
    stall_i = 0;
    if (beats < n) begin
      failures++;
      $display("FAIL beat_timeout actual=%0d required=%0d", beats, n);
    end
    for (int i = 0; i < 2; i++) begin
      edge_val_i = 1'($urandom % 2);
      step();
    end
    edge_val_i = 0;
  endtask

  initial begin
    int col_writes, row_writes;
    logic [1:0] s;
    logic [3:0] msk;
    repeat (3) step();
    chk("lit_reset_cmd_rdy", cmd_rdy_o, 1);
    rstn = 0;
    step();

    // 4x4 TU at x=2,y=3, single beat
    send_cmd(2'd0, 4'd2, 4'd3, 6'd0);
    edge_val_i = 1; edge_row_dat_i = 32'h11223344; edge_col_dat_i = 32'h55667788;
    step();
    edge_val_i = 0;
    #1;
    chk("lit_t1_row_adr", row_wr_adr_o, 8'h32);
    chk("lit_t1_col_adr", col_wr_adr_o, 8'h23);
    chk("lit_t1_row_dat", row_wr_dat_o, 32'h11223344);
    chk("lit_t1_col_dat", col_wr_dat_o, 32'h55667788);
    chk("lit_t1_done", done_o, 1);
    chk("lit_t1_fra_ena", fra_wr_ena_o, 0);
    repeat (2) step();

    // 16x16 at x=4,y=8: all-valid beats, then with a 3-cycle stall
    run_tu(2'd2, 4'd4, 4'd8, 6'd1, 0, 0);
    run_tu(2'd2, 4'd4, 4'd8, 6'd1, 2, 0);

    // 32x32 at x=0,y=8, lcu_x=5: LCU-bottom TU
    send_cmd(2'd3, 4'd0, 4'd8, 6'd5);
    col_writes = 0; row_writes = 0;
    edge_val_i = 1;
    for (int i = 0; i < 8; i++) begin
      edge_row_dat_i = $urandom; edge_col_dat_i = $urandom;
      step();
      col_writes += int'(col_wr_ena_o);
      row_writes += int'(row_wr_ena_o);
      if (i == 0) begin
        #1;
        chk("lit_t3_col_adr0", col_wr_adr_o, 8'h78);
        chk("lit_t3_fra_ena0", fra_wr_ena_o, FRA_EN);
        if (FRA_EN) chk("lit_t3_fra_adr0", fra_wr_adr_o, 10'h050);
      end
    end
    edge_val_i = 0;
    chk("lit_t3_col_writes", col_writes, 8);
    chk("lit_t3_row_writes", row_writes, 0);
    chk("lit_t3_done", done_o, 1);
    repeat (2) step();

    // Reset after beat 2 of 8, then a normal TU
    run_tu(2'd3, 4'd0, 4'd0, 6'd3, 0, 2);
    chk("lit_post_rst_cmd_rdy", cmd_rdy_o, 1);
    run_tu(2'd1, 4'd6, 4'd2, 6'd7, 0, 0);

    for (int t = 0; t < 60; t++) begin
      s = 2'($urandom);
      msk = ~(4'((1 << s) - 1));
      run_tu(s, 4'($urandom) & msk, 4'($urandom) & msk, PXW'($urandom), 1, 0);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
